fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch stage that sits directly upstream of the segmented memory's instruction port.
- Owns the fetch PC and drives the instruction-segment address.
- Captures the returned 16-bit instruction into a small prefetch FIFO, tagged with its PC.
- Presents instructions to decode over a valid/ready handshake; a redirect (branch/jump) flushes all speculative fetches.

Parameters:
WIDTH, 32, address/PC width
INSTRUCTIONWIDTH, 16, instruction width
DEPTH, 4, prefetch FIFO entries; power of two, 2..16 (full throughput needs DEPTH>=3)
RESETPC, 0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  WIDTH  instruction-segment address, driven from fetch_pc register
imem_rdata  in  INSTRUCTIONWIDTH  instruction word, valid the cycle after imem_addr is presented
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  WIDTH  new fetch PC
instr_valid  out  1  FIFO head holds a valid instruction
instr  out  INSTRUCTIONWIDTH  FIFO head instruction
instr_pc  out  WIDTH  PC of FIFO head
instr_ready  in  1  decode accepts head this cycle

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset values: fetch_pc=RESETPC (so imem_addr=RESETPC); count=0; pending=0; rd/wr pointers=0; instr_valid=0; instr=0; instr_pc=0.
- Memory latency: exactly 1 cycle. imem_addr = fetch_pc is presented in cycle N. imem_rdata is sampled at the end of cycle N+1. At most one request is outstanding, tracked by the pending flag and pending_pc.
- Issue condition (evaluated each cycle): issue = !redirect && (count + pending < DEPTH).
- On issue: fetch_pc <= fetch_pc+1 (modulo 2^WIDTH, wraps silently); pending <= 1; pending_pc <= fetch_pc.
- Without issue: pending <= 0 and fetch_pc is held.
- Capture: if pending && !redirect at an edge, push {pending_pc, imem_rdata} at wr_ptr.
  - The issue rule reserves the slot, so a push never overflows.
- Pop: pop = instr_valid && instr_ready. It advances rd_ptr.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Outputs are combinational from the FIFO head:
  - instr_valid = (count != 0).
  - instr and instr_pc are the head entry; they hold their last values when empty.
- Redirect (dominates every other event in that cycle):
  - count <= 0; pointers <= 0; pending <= 0; fetch_pc <= redirect_pc; no issue.
  - Data returning in the next cycle for an in-flight request is discarded.
  - A pop in the same cycle is lost; decode must treat redirect as killing its own input.
  - First instr_valid after redirect: 2 cycles later, for redirect_pc.
- Startup latency: first edge after reset deassert issues RESETPC. The second edge captures it. instr_valid=1 after the second edge.
- Steady state, DEPTH>=3, instr_ready held 1: one instruction per cycle, PCs consecutive.
- Back-pressure: with instr_ready=0, the FIFO fills to DEPTH and issue stops. imem_addr holds the next unfetched PC; nothing is dropped or duplicated.
- reset asserted mid-operation: all state returns to reset values immediately (async). Any in-flight data is ignored.

Test Plan:
- Reset release, imem model returns mem[a]=a+16'h100, instr_ready=1 -> instr_valid rises after 2nd edge with instr_pc=0, instr=0x0100. Then pcs 1,2,3… each cycle with no bubbles.
- instr_ready=0 from start -> count reaches 4, imem_addr stops at 4, outputs hold pc 0. Raise ready -> pcs 0..7 delivered in order, none skipped or repeated.
- Steady stream, redirect with redirect_pc=0x40 while pending and FIFO holds 3 -> next cycle instr_valid=0. Two cycles later instr_pc=0x40, followed by 0x41. No pre-redirect PC appears.
- Pop and capture in the same cycle with count=DEPTH-1 -> count unchanged, order preserved across pointer wrap (≥3 full FIFO wraps).
- RESETPC=32'hFFFF_FFFE, free-running -> pcs FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Assert reset while FIFO holds 2 and a request is pending -> instr_valid=0 immediately. After release, first instr_pc=RESETPC; stale data never appears.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, issues one-cycle-latency reads to the
// instruction segment and queues returned words (tagged with their PC) for decode.
module fetch_buffer #(
    parameter int unsigned      WIDTH            = 32,
    parameter int unsigned      INSTRUCTIONWIDTH = 16,
    parameter int unsigned      DEPTH            = 4,
    parameter logic [WIDTH-1:0] RESETPC          = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
    input  logic                        redirect,
    input  logic [WIDTH-1:0]            redirect_pc,
    output logic                        instr_valid,
    output logic [INSTRUCTIONWIDTH-1:0] instr,
    output logic [WIDTH-1:0]            instr_pc,
    input  logic                        instr_ready
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0]            fetch_pc,   fetch_pc_n;
    logic                        pending,    pending_n;
    logic [WIDTH-1:0]            pending_pc, pending_pc_n;
    logic [CW-1:0]               count,      count_n;
    logic [PW-1:0]               rd_ptr,     rd_ptr_n;
    logic [PW-1:0]               wr_ptr,     wr_ptr_n;
    logic [INSTRUCTIONWIDTH-1:0] hold_instr;
    logic [WIDTH-1:0]            hold_pc;

    logic [INSTRUCTIONWIDTH-1:0] mem_data [DEPTH];
    logic [WIDTH-1:0]            mem_pc   [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // An issue reserves a FIFO slot, so a capture can never overflow.
    assign issue = !redirect && ((count + CW'(pending)) < DEPTH_C);
    assign push  = pending && !redirect;
    assign pop   = instr_valid && instr_ready && !redirect;

    always_comb begin
        fetch_pc_n   = fetch_pc;
        pending_n    = 1'b0;
        pending_pc_n = pending_pc;
        count_n      = count;
        rd_ptr_n     = rd_ptr;
        wr_ptr_n     = wr_ptr;
        if (redirect) begin
            fetch_pc_n = redirect_pc;
            count_n    = '0;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
        end else begin
            if (issue) begin
                fetch_pc_n   = fetch_pc + WIDTH'(1);
                pending_n    = 1'b1;
                pending_pc_n = fetch_pc;
            end
            if (push) wr_ptr_n = wr_ptr + PW'(1);
            if (pop)  rd_ptr_n = rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_n = count + CW'(1);
                2'b01:   count_n = count - CW'(1);
                default: count_n = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESETPC;
            pending    <= 1'b0;
            pending_pc <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            pending    <= pending_n;
            pending_pc <= pending_pc_n;
            count      <= count_n;
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            if (instr_valid) begin
                hold_instr <= mem_data[rd_ptr];
                hold_pc    <= mem_pc[rd_ptr];
            end
        end
    end

    // Storage needs no reset: only entries written since the last flush are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= pending_pc;
        end
    end

    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem_data[rd_ptr] : hold_instr;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : hold_pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a scoreboard of expected (pc, instr) pairs fed by reset/redirect
// stimulus, a decoupled monitor that checks every pop, plus directed timing checks.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_addr, a_redirect_pc, a_pc;
    logic [15:0] a_rdata, a_instr;
    logic        a_redirect, a_valid, a_ready;
    logic [31:0] b_addr, b_pc, b_redirect_pc;
    logic [15:0] b_rdata, b_instr;
    logic        b_redirect, b_valid, b_ready;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fill_pc;
    logic [31:0] b_exp;

    always #5 clk = ~clk;

    fetch_buffer dut_a (
        .clk(clk), .reset(reset), .imem_addr(a_addr), .imem_rdata(a_rdata),
        .redirect(a_redirect), .redirect_pc(a_redirect_pc), .instr_valid(a_valid),
        .instr(a_instr), .instr_pc(a_pc), .instr_ready(a_ready)
    );

    fetch_buffer #(.RESETPC(32'hFFFF_FFFE)) dut_b (
        .clk(clk), .reset(reset), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .redirect(b_redirect), .redirect_pc(b_redirect_pc), .instr_valid(b_valid),
        .instr(b_instr), .instr_pc(b_pc), .instr_ready(b_ready)
    );

    function automatic logic [15:0] memf(input logic [31:0] a);
        return a[15:0] + 16'h0100;
    endfunction

    // One-cycle-latency instruction memory models
    always @(posedge clk) begin
        a_rdata <= memf(a_addr);
        b_rdata <= memf(b_addr);
    end

    function automatic void sb_top();
        exp_t e;
        while (sb.size() < 16) begin
            e.pc  = fill_pc;
            e.ins = memf(fill_pc);
            sb.push_back(e);
            fill_pc = fill_pc + 32'd1;
        end
    endfunction

    function automatic void sb_restart(input logic [31:0] pc);
        sb.delete();
        fill_pc = pc;
        sb_top();
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor for instance A: every accepted head must match the next scoreboard entry
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && !a_redirect && a_valid && a_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL sb_empty: pop of pc %0h with nothing expected", a_pc);
            end else begin
                e = sb.pop_front();
                check("a_pc", a_pc, e.pc);
                check("a_instr", a_instr, e.ins);
                sb_top();
            end
        end
    end

    // Monitor for instance B: free-running stream across the 32-bit PC wrap
    always @(negedge clk) begin
        if (reset) begin
            b_exp = 32'hFFFF_FFFE;
        end else if (b_valid) begin
            check("b_pc", b_pc, b_exp);
            check("b_instr", b_instr, memf(b_exp));
            b_exp = b_exp + 32'd1;
        end
    end

    initial begin
        int thr;
        reset = 1'b1;
        a_redirect = 1'b0; a_redirect_pc = '0; a_ready = 1'b1;
        b_redirect = 1'b0; b_redirect_pc = '0; b_ready = 1'b1;
        sb_restart(32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", a_valid, 1'b0);
        check("rst_addr", a_addr, 32'd0);
        check("rst_instr", a_instr, 16'd0);
        check("rst_pc", a_pc, 32'd0);
        check("rst_b_addr", b_addr, 32'hFFFF_FFFE);

        // Startup latency and no-bubble streaming
        @(posedge clk); #1 reset = 1'b0; sb_restart(32'd0);
        @(negedge clk); check("start_e0_valid", a_valid, 1'b0);
        @(negedge clk); check("start_e1_valid", a_valid, 1'b0);
        @(negedge clk); check("start_e2_valid", a_valid, 1'b1);
        check("start_e2_pc", a_pc, 32'd0);
        check("start_e2_instr", a_instr, 16'h0100);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); check("stream_valid", a_valid, 1'b1);
        end

        // Back-pressure from reset: fill to DEPTH, fetch stalls at pc 4
        @(posedge clk); #1 reset = 1'b1; a_ready = 1'b0;
        @(posedge clk); #1 reset = 1'b0; sb_restart(32'd0);
        repeat (10) @(negedge clk);
        check("bp_addr", a_addr, 32'd4);
        check("bp_valid", a_valid, 1'b1);
        check("bp_pc", a_pc, 32'd0);
        check("bp_instr", a_instr, 16'h0100);
        @(posedge clk); #1 a_ready = 1'b1;
        repeat (12) @(posedge clk);

        // Redirect while FIFO holds 3 and a request is in flight
        #1 a_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 a_redirect = 1'b1; a_redirect_pc = 32'h40; a_ready = 1'b1; sb_restart(32'h40);
        @(negedge clk); check("redir_pre_valid", a_valid, 1'b1);
        @(posedge clk); #1 a_redirect = 1'b0;
        @(negedge clk); check("redir_r1_valid", a_valid, 1'b0);
        @(negedge clk); check("redir_r2_valid", a_valid, 1'b0);
        @(negedge clk); check("redir_r3_valid", a_valid, 1'b1);
        check("redir_r3_pc", a_pc, 32'h40);
        repeat (6) @(posedge clk);

        // Asynchronous reset with 2 entries queued and one pending
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; a_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid_pre_valid", a_valid, 1'b1);
        check("mid_pre_addr", a_addr, 32'd3);
        reset = 1'b1;
        #1 check("mid_rst_valid", a_valid, 1'b0);
        check("mid_rst_addr", a_addr, 32'd0);
        check("mid_rst_pc", a_pc, 32'd0);
        @(posedge clk); #1 reset = 1'b0; a_ready = 1'b1; sb_restart(32'd0);
        @(negedge clk); @(negedge clk);
        check("mid_post_e1_valid", a_valid, 1'b0);
        @(negedge clk);
        check("mid_post_valid", a_valid, 1'b1);
        check("mid_post_pc", a_pc, 32'd0);

        // Randomized ready/redirect traffic checked by the scoreboard
        thr = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (c % 200 == 0) thr = int'($urandom_range(3));
            a_ready = (int'($urandom_range(3)) >= thr);
            if (a_redirect) begin
                a_redirect = 1'b0;
            end else if ($urandom_range(49) == 0) begin
                a_redirect    = 1'b1;
                a_redirect_pc = $urandom_range(1) != 0 ? $urandom()
                                : 32'hFFFF_FFF8 + 32'($urandom_range(7));
                sb_restart(a_redirect_pc);
            end
        end
        @(posedge clk); #1 a_redirect = 1'b0; a_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
